oam_dma_controller: RTL and testbench
=====================================

# oam_dma_controller

Sequences the Game Boy OAM DMA transfer: a CPU write to register FF46 copies 160 bytes from source page `{FF46, 8'h00}` into sprite attribute memory FE00–FE9F. It sits beside the MMU and owns the shared memory read port for the duration of the transfer. It requests each read through a grant handshake, so the GPU/MMU arbiter can stall it. While the transfer runs, it tells the MMU to block CPU bus accesses outside high RAM.

## Interface
Parameters:
- pRegAddr, 16'hFF46, CPU-visible DMA source/start register address
- pLength, 160, bytes per transfer
- pEchoBase, 8'hE0, pages at or above this value are aliased down by 8'h20 (echo RAM)

Ports:
- iClock  in  1  system clock; all state changes on its rising edge
- iReset  in  1  asynchronous, active-low reset
- iCpuWe  in  1  CPU write strobe, as presented to the MMU
- iCpuAddr  in  16  CPU address
- iCpuData  in  8  CPU write data
- oRegData  out  8  readback of FF46 (last written page)
- oDmaReadReq  out  1  read request on the shared memory port
- oDmaAddr  out  16  read address, `{effective page, idx}`
- iDmaGrant  in  1  arbiter grant; the read is accepted on an edge where req and grant are both 1
- iDmaData  in  8  read data, valid the cycle after acceptance
- oOamWe  out  1  OAM write strobe
- oOamAddr  out  8  OAM byte index, 0..159
- oOamData  out  8  OAM write data
- oBusy  out  1  transfer in progress (ARM, RD or WR)
- oCpuBlock  out  1  MMU must block CPU accesses outside FF80–FFFE
- oDone  out  1  one-cycle pulse after the last byte is written

## Operation
- States:
  - IDLE: no transfer.
  - ARM: one-cycle start delay.
  - RD: issue read; stays in RD until the grant handshake.
  - WR: write the byte to OAM.
- Start: an edge with iCpuWe=1 and iCpuAddr==pRegAddr latches iCpuData into the page register. On the same edge, idx is cleared to 0 and the state goes to ARM.
- ARM → RD unconditionally.
- RD:
  - oDmaReadReq=1, oDmaAddr = `{page>=pEchoBase ? page-8'h20 : page, idx}`.
  - On an edge with iDmaGrant=1, go to WR. Otherwise hold; address and req stay stable.
- WR:
  - oOamWe=1, oOamAddr=idx, oOamData=iDmaData (combinational pass-through).
  - If idx==pLength-1, go to IDLE and register oDone=1 for the next cycle.
  - Otherwise increment idx and go to RD.
- Restart: a start write while busy takes priority over all state transitions and forces ARM with idx=0 and the new page. A WR occurring in that same cycle still performs its OAM write; no oDone pulse is produced for the aborted transfer.
- oCpuBlock = 1 in RD and WR, 0 in IDLE and ARM.
- oRegData always returns the latched page. Writes to other addresses have no effect.
- idx is 8 bits wide and never exceeds pLength-1. No wrap past 159 is permitted.

## Timing
- Reset values: state IDLE, idx 0, page 8'hFF. oRegData 8'hFF. oDmaAddr 16'h0000. All strobes (oDmaReadReq, oOamWe, oBusy, oCpuBlock, oDone) 0. oOamAddr 0, oOamData 0.
- Reset asserted mid-transfer clears everything immediately (asynchronously). No further OAM writes occur, and no oDone pulse is produced.
- Start write sampled at edge T: ARM during T..T+1, first RD during T+1..T+2.
- With continuous grant, each byte takes 2 cycles. The last WR occurs in cycle T+320 and oDone is high in T+321. Total = 1 + 2·pLength cycles.
- Each cycle with iDmaGrant=0 in RD adds exactly one cycle of latency. No bytes are skipped or duplicated.
- Start write and last WR in the same cycle: the byte-159 write commits, the transfer restarts, and oDone stays 0.

## Test plan
- Reset, then write 8'hC0 to FF46 with grant tied high:
  - 160 OAM writes with oOamAddr 0..159 and oDmaAddr C000..C09F.
  - oDone pulses exactly at T+321.
  - oBusy deasserts at the same time.
- Write 8'hE1 to FF46:
  - oDmaAddr runs C100..C19F (echo alias).
  - oRegData reads 8'hE1.
- Random grant with 50% duty:
  - OAM contents equal source bytes 0..159 in order.
  - oDmaAddr is stable while req=1 and grant=0.
  - Exactly 160 oOamWe pulses.
- Restart: write 8'hC0, then write 8'hD0 after 40 WRs:
  - 40 writes from C0xx, then a full 160 from D000..D09F.
  - One oDone pulse only.
- Assert iReset=0 at byte 75:
  - All outputs return to reset values within the same cycle.
  - No OAM writes after release until a new FF46 write.
- Write 8'h55 to FF45 and to FF47: no transfer starts, and oRegData is unchanged.

Source files
------------

// File: rtl/oam_dma_controller_if.sv
// Shared-memory read port and OAM write port of the OAM DMA engine.
// The master side is the DMA controller; the slave side is the arbiter/memory/OAM.
interface oam_dma_controller_if;
  logic        oDmaReadReq;
  logic [15:0] oDmaAddr;
  logic        iDmaGrant;
  logic [7:0]  iDmaData;
  logic        oOamWe;
  logic [7:0]  oOamAddr;
  logic [7:0]  oOamData;

  modport master (
    output oDmaReadReq, oDmaAddr,
    input  iDmaGrant, iDmaData,
    output oOamWe, oOamAddr, oOamData
  );

  modport slave (
    input  oDmaReadReq, oDmaAddr,
    output iDmaGrant, iDmaData,
    input  oOamWe, oOamAddr, oOamData
  );
endinterface

// File: rtl/oam_dma_controller.sv
// Game Boy OAM DMA sequencer: copies pLength bytes from page {FF46, 00} into OAM
// through a granted read port, and asks the MMU to fence the CPU into high RAM meanwhile.
module oam_dma_controller #(
  parameter logic [15:0] pRegAddr  = 16'hFF46,
  parameter int          pLength   = 160,
  parameter logic [7:0]  pEchoBase = 8'hE0
) (
  input  logic                        iClock,
  input  logic                        iReset,
  input  logic                        iCpuWe,
  input  logic [15:0]                 iCpuAddr,
  input  logic [7:0]                  iCpuData,
  output logic [7:0]                  oRegData,
  oam_dma_controller_if.master        dmaBus,
  output logic                        oBusy,
  output logic                        oCpuBlock,
  output logic                        oDone
);

  typedef enum logic [1:0] {
    sIdle,
    sArm,
    sRd,
    sWr
  } stateT;

  localparam logic [7:0] cLastIdx = 8'(pLength - 1);

  stateT      state, nextState;
  logic [7:0] idx, nextIdx;
  logic [7:0] page, nextPage;
  logic [7:0] effPage;
  logic       doneQ, nextDone;
  logic       startWr;

  assign startWr = iCpuWe && (iCpuAddr == pRegAddr);

  // Echo RAM (E000-FDFF) mirrors C000-DDFF, so the read port only ever sees the real page.
  assign effPage = (page >= pEchoBase) ? (page - 8'h20) : page;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state <= sIdle;
      idx   <= '0;
      page  <= 8'hFF;
      doneQ <= 1'b0;
    end else begin
      state <= nextState;
      idx   <= nextIdx;
      page  <= nextPage;
      doneQ <= nextDone;
    end
  end

  // NOTE: every signal gets a default before the case, so no path can infer a latch.
  always_comb begin
    nextState          = state;
    nextIdx            = idx;
    nextPage           = page;
    nextDone           = 1'b0;
    dmaBus.oDmaReadReq = 1'b0;
    dmaBus.oDmaAddr    = 16'h0000;
    dmaBus.oOamWe      = 1'b0;
    dmaBus.oOamAddr    = 8'h00;
    dmaBus.oOamData    = 8'h00;

    case (state)
      sIdle: ;
      sArm:  nextState = sRd;
      sRd: begin
        dmaBus.oDmaReadReq = 1'b1;
        dmaBus.oDmaAddr    = {effPage, idx};
        if (dmaBus.iDmaGrant) nextState = sWr;
      end
      sWr: begin
        dmaBus.oOamWe   = 1'b1;
        dmaBus.oOamAddr = idx;
        dmaBus.oOamData = dmaBus.iDmaData;
        if (idx == cLastIdx) begin
          nextState = sIdle;
          nextDone  = 1'b1;
        end else begin
          nextIdx   = idx + 8'd1;
          nextState = sRd;
        end
      end
      default: nextState = sIdle;
    endcase

    // A start write overrides whatever the sequencer was doing; the current WR still lands.
    if (startWr) begin
      nextState = sArm;
      nextIdx   = '0;
      nextPage  = iCpuData;
      nextDone  = 1'b0;
    end
  end

  assign oRegData  = page;
  assign oBusy     = (state != sIdle);
  assign oCpuBlock = (state == sRd) || (state == sWr);
  assign oDone     = doneQ;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Self-checking bench for oam_dma_controller: a byte-level transfer model checked every
// cycle, a simple memory/arbiter responder, and directed scenarios with literal expectations.
module tb_oam_dma_controller;

  logic        iClock   = 1'b0;
  logic        iReset   = 1'b1;
  logic        iCpuWe   = 1'b0;
  logic [15:0] iCpuAddr = 16'h0000;
  logic [7:0]  iCpuData = 8'h00;
  logic [7:0]  oRegData;
  logic        oBusy, oCpuBlock, oDone;

  oam_dma_controller_if dmaBus ();

  oam_dma_controller dut (
    .iClock    (iClock),
    .iReset    (iReset),
    .iCpuWe    (iCpuWe),
    .iCpuAddr  (iCpuAddr),
    .iCpuData  (iCpuData),
    .oRegData  (oRegData),
    .dmaBus    (dmaBus),
    .oBusy     (oBusy),
    .oCpuBlock (oCpuBlock),
    .oDone     (oDone)
  );

  always #5 iClock = ~iClock;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Source memory and read-port responder: data follows one cycle after an accepted read.
  logic [7:0] mem [65536];
  logic [7:0] rdData = 8'h00;
  bit         randomGrant = 1'b0;
  assign dmaBus.iDmaData = rdData;

  always @(posedge iClock)
    if (dmaBus.oDmaReadReq && dmaBus.iDmaGrant) rdData <= mem[dmaBus.oDmaAddr];

  initial begin
    dmaBus.iDmaGrant = 1'b1;
    forever begin
      @(posedge iClock);
      #1;
      dmaBus.iDmaGrant = randomGrant ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  int cyc = 0;
  always @(posedge iClock) cyc <= cyc + 1;

  function automatic logic [7:0] eff(input logic [7:0] p);
    return (p >= 8'hE0) ? p - 8'h20 : p;
  endfunction

  // Transfer model: which byte is next, and whether this cycle is the start delay,
  // a pending read, or the write of the byte just fetched.
  bit         mActive, mArm, mWriting, mDone, expReq;
  int         mIdx;
  logic [7:0] mPage = 8'hFF;
  bit         startNow, nextDone;

  // Observations of the DUT used by the directed scenarios.
  int         wrCount, doneCount, doneCyc, firstAddr, lastAddr;
  logic [7:0] oamMem [160];

  always @(negedge iClock) begin
    if (!iReset) begin
      mActive = 0; mArm = 0; mWriting = 0; mDone = 0; mIdx = 0; mPage = 8'hFF;
    end else begin
      expReq = mActive && !mArm && !mWriting;
      check("regData", oRegData, mPage);
      check("busy", oBusy, mActive);
      check("cpuBlock", oCpuBlock, mActive && !mArm);
      check("done", oDone, mDone);
      check("readReq", dmaBus.oDmaReadReq, expReq);
      check("oamWe", dmaBus.oOamWe, mWriting);
      if (expReq) check("dmaAddr", dmaBus.oDmaAddr, {eff(mPage), 8'(mIdx)});
      if (mWriting) begin
        check("oamAddr", dmaBus.oOamAddr, mIdx);
        check("oamData", dmaBus.oOamData, mem[{eff(mPage), 8'(mIdx)}]);
      end

      if (dmaBus.oOamWe) begin
        wrCount++;
        if (dmaBus.oOamAddr < 8'd160) oamMem[dmaBus.oOamAddr] = dmaBus.oOamData;
      end
      if (oDone) begin
        doneCount++;
        doneCyc = cyc;
      end
      if (dmaBus.oDmaReadReq) begin
        if (firstAddr < 0) firstAddr = int'(dmaBus.oDmaAddr);
        lastAddr = int'(dmaBus.oDmaAddr);
      end

      // Advance to the next cycle using the inputs the DUT will sample at the coming edge.
      startNow = iCpuWe && (iCpuAddr == 16'hFF46);
      nextDone = 0;
      if (mWriting) begin
        mWriting = 0;
        if (mIdx == 159) begin
          mActive  = 0;
          nextDone = 1;
        end else mIdx++;
      end else if (mArm) mArm = 0;
      else if (mActive && dmaBus.iDmaGrant) mWriting = 1;
      if (startNow) begin
        mPage = iCpuData; mActive = 1; mArm = 1; mWriting = 0; mIdx = 0; nextDone = 0;
      end
      mDone = nextDone;
    end
  end

  task automatic driveStart(input logic [7:0] page, input logic [15:0] addr);
    @(posedge iClock); #1;
    iCpuWe = 1'b1; iCpuAddr = addr; iCpuData = page;
    @(posedge iClock); #1;
    iCpuWe = 1'b0; iCpuAddr = 16'h0000; iCpuData = 8'h00;
  endtask

  task automatic clearObs();
    wrCount = 0; doneCount = 0; doneCyc = -1; firstAddr = -1; lastAddr = -1;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (oBusy && n < budget) begin
      @(posedge iClock); #1;
      n++;
    end
    check("idleWithinBudget", oBusy, 1'b0);
    repeat (2) @(posedge iClock);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_regData"}, oRegData, 8'hFF);
    check({tag, "_readReq"}, dmaBus.oDmaReadReq, 1'b0);
    check({tag, "_dmaAddr"}, dmaBus.oDmaAddr, 16'h0000);
    check({tag, "_oamWe"}, dmaBus.oOamWe, 1'b0);
    check({tag, "_oamAddr"}, dmaBus.oOamAddr, 8'h00);
    check({tag, "_oamData"}, dmaBus.oOamData, 8'h00);
    check({tag, "_busy"}, oBusy, 1'b0);
    check({tag, "_cpuBlock"}, oCpuBlock, 1'b0);
    check({tag, "_done"}, oDone, 1'b0);
  endtask

  initial begin
    int startCyc, bad, n, savedWr;
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a * 7 + (a >> 8) * 13 + 5);
    clearObs();

    #1 iReset = 1'b0;
    #1 checkResetOutputs("reset");
    #21 iReset = 1'b1;
    repeat (2) @(posedge iClock);
    #1;

    // Grant tied high: 1 + 2*160 cycles, done in cycle T+321.
    clearObs();
    driveStart(8'hC0, 16'hFF46);
    startCyc = cyc;
    waitIdle(400);
    check("c0_writes", wrCount, 160);
    check("c0_doneCount", doneCount, 1);
    check("c0_doneLatency", doneCyc - startCyc, 321);
    check("c0_firstAddr", firstAddr, 32'hC000);
    check("c0_lastAddr", lastAddr, 32'hC09F);
    check("c0_oam0", oamMem[0], mem[16'hC000]);
    check("c0_oam159", oamMem[159], mem[16'hC09F]);

    // Echo page E1 reads from C1xx.
    clearObs();
    driveStart(8'hE1, 16'hFF46);
    waitIdle(400);
    check("e1_writes", wrCount, 160);
    check("e1_firstAddr", firstAddr, 32'hC100);
    check("e1_lastAddr", lastAddr, 32'hC19F);
    check("e1_regData", oRegData, 8'hE1);

    // Random 50% grant: every byte still copied once, in order.
    clearObs();
    randomGrant = 1'b1;
    driveStart(8'hC2, 16'hFF46);
    waitIdle(2000);
    randomGrant = 1'b0;
    bad = 0;
    for (int i = 0; i < 160; i++)
      if (oamMem[i] !== mem[16'hC200 + i]) bad++;
    check("rnd_writes", wrCount, 160);
    check("rnd_doneCount", doneCount, 1);
    check("rnd_badBytes", bad, 0);

    // Restart after 40 writes: start sampled at the end of the 40th WR (cycle T+80).
    clearObs();
    driveStart(8'hC0, 16'hFF46);
    repeat (79) @(posedge iClock);
    driveStart(8'hD0, 16'hFF46);
    check("rs_writesBefore", wrCount, 40);
    waitIdle(400);
    check("rs_writesTotal", wrCount, 200);
    check("rs_doneCount", doneCount, 1);
    check("rs_firstAddr", firstAddr, 32'hC000);
    check("rs_lastAddr", lastAddr, 32'hD09F);
    check("rs_regData", oRegData, 8'hD0);

    // Start write coinciding with the last WR: byte 159 commits, no done, restart.
    clearObs();
    driveStart(8'hC4, 16'hFF46);
    repeat (319) @(posedge iClock);
    driveStart(8'hC5, 16'hFF46);
    repeat (2) @(posedge iClock);
    #1;
    check("lw_writesFirst", wrCount, 160);
    check("lw_noDone", doneCount, 0);
    check("lw_busy", oBusy, 1'b1);
    waitIdle(400);
    check("lw_writesTotal", wrCount, 320);
    check("lw_doneCount", doneCount, 1);
    check("lw_lastAddr", lastAddr, 32'hC59F);

    // Asynchronous reset at byte 75.
    clearObs();
    driveStart(8'hC0, 16'hFF46);
    n = 0;
    while (wrCount < 75 && n < 500) begin
      @(posedge iClock); #1;
      n++;
    end
    check("rst_reached75", wrCount, 75);
    #2 iReset = 1'b0;
    #1 checkResetOutputs("midReset");
    savedWr = wrCount;
    repeat (3) @(posedge iClock);
    #2 iReset = 1'b1;
    repeat (20) @(posedge iClock);
    #1;
    check("rst_noMoreWrites", wrCount, savedWr);
    check("rst_noDone", doneCount, 0);
    check("rst_busy", oBusy, 1'b0);

    // Neighbouring registers do not start a transfer or touch the page.
    clearObs();
    driveStart(8'h55, 16'hFF45);
    driveStart(8'h55, 16'hFF47);
    repeat (10) @(posedge iClock);
    #1;
    check("nb_busy", oBusy, 1'b0);
    check("nb_writes", wrCount, 0);
    check("nb_regData", oRegData, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
